// File: rtl/cpu_mem_bridge_pkg.sv
// cpu_mem_bridge_pkg
// Shared definitions for the CPU-to-memory bridge:
//   - FSM state encoding (IDLE, MEM, RESP)
//   - lane_bits(): number of byte-lane address bits for a memory word width
//   - BUS_ERR_DATA: byte returned to the CPU when a read times out
package cpu_mem_bridge_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [7:0] BUS_ERR_DATA = 8'hFF;

    // Byte-lane select width for an MW-bit memory word (MW = 16, 32 or 64).
    function automatic int lane_bits(input int mw);
        return $clog2(mw / 8);
    endfunction

endpackage

// File: rtl/cpu_mem_bridge_line_buffer.sv
// line_buffer
// One-line read buffer holding a single memory word, its word-address tag
// and a valid bit. A read fill replaces the whole line; a write that hits
// the held line updates one byte lane so the buffer never goes stale.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears valid)
//   fill_en/tag/data    load a complete line from a memory read
//   wr_en/tag/lane/byte write-through of one byte, applied only on a tag hit
//   rd_tag/rd_lane      lookup address from the CPU
//   hit                 line valid and tag matches rd_tag
//   rd_byte             selected lane of the held line
// With BUF_EN = 0 the storage is not built and hit is constant 0.
module line_buffer
    import cpu_mem_bridge_pkg::*;
#(
    parameter int TW     = 19,
    parameter int MW     = 16,
    parameter int BUF_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fill_en,
    input  logic [TW-1:0]              fill_tag,
    input  logic [MW-1:0]              fill_data,
    input  logic                       wr_en,
    input  logic [TW-1:0]              wr_tag,
    input  logic [lane_bits(MW)-1:0]   wr_lane,
    input  logic [7:0]                 wr_byte,
    input  logic [TW-1:0]              rd_tag,
    input  logic [lane_bits(MW)-1:0]   rd_lane,
    output logic                       hit,
    output logic [7:0]                 rd_byte
);

    generate
        if (BUF_EN != 0) begin : g_buf
            logic          valid;
            logic [TW-1:0] tag;
            logic [MW-1:0] data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid <= 1'b0;
                end else if (fill_en) begin
                    valid <= 1'b1;
                end
            end

            // Tag and data are only meaningful while valid is set, so they
            // carry no reset.
            always_ff @(posedge clk) begin
                if (fill_en) begin
                    tag  <= fill_tag;
                    data <= fill_data;
                end else if (wr_en && valid && (tag == wr_tag)) begin
                    data[{wr_lane, 3'b000} +: 8] <= wr_byte;
                end
            end

            assign hit     = valid && (tag == rd_tag);
            assign rd_byte = data[{rd_lane, 3'b000} +: 8];
        end else begin : g_nobuf
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, fill_en, fill_tag, fill_data,
                                     wr_en, wr_tag, wr_lane, wr_byte,
                                     rd_tag, rd_lane};
            assign hit     = 1'b0;
            assign rd_byte = 8'h00;
        end
    endgenerate

endmodule

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge
// Bridges the byte-wide CPU bus to a word-organised memory port with a
// request/ack handshake, byte-lane enables, a one-line read buffer and a
// bus timeout.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cpu_a         CPU byte address
//   cpu_o         CPU write data
//   cpu_i         CPU read data (registered)
//   cpu_w         1 = write, 0 = read
//   cpu_req       access request, held until cpu_ready
//   cpu_ready     one-cycle completion pulse
//   bus_err       sticky timeout flag, cleared by err_clr
//   err_clr       clears bus_err (wins over a simultaneous timeout)
//   mem_addr      memory word address
//   mem_wdata     cpu_o replicated on every lane
//   mem_be        one-hot lane on writes, all ones on reads
//   mem_we        memory write
//   mem_req       memory request level, held until mem_ack or timeout
//   mem_ack       memory completion, read data valid in the same cycle
//   mem_rdata     memory read data
module cpu_mem_bridge
    import cpu_mem_bridge_pkg::*;
#(
    parameter int AW      = 20,
    parameter int MW      = 16,
    parameter int TIMEOUT = 255,
    parameter int BUF_EN  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AW-1:0]                 cpu_a,
    input  logic [7:0]                    cpu_o,
    output logic [7:0]                    cpu_i,
    input  logic                          cpu_w,
    input  logic                          cpu_req,
    output logic                          cpu_ready,
    output logic                          bus_err,
    input  logic                          err_clr,
    output logic [AW-lane_bits(MW)-1:0]   mem_addr,
    output logic [MW-1:0]                 mem_wdata,
    output logic [MW/8-1:0]               mem_be,
    output logic                          mem_we,
    output logic                          mem_req,
    input  logic                          mem_ack,
    input  logic [MW-1:0]                 mem_rdata
);

    localparam int         LB      = lane_bits(MW);
    localparam int         NL      = MW / 8;
    localparam int         WW      = AW - LB;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    function automatic logic [7:0] pick_lane(input logic [MW-1:0] w,
                                             input logic [LB-1:0] l);
        return w[{l, 3'b000} +: 8];
    endfunction

    state_t        state;
    logic [LB-1:0] lane_q;
    logic [7:0]    byte_q;
    logic [7:0]    cnt;

    logic [WW-1:0] cpu_word;
    logic [LB-1:0] cpu_lane;
    logic [NL-1:0] lane_onehot;
    logic          buf_hit;
    logic [7:0]    buf_byte;
    logic          acked;
    logic          timeout;

    assign cpu_word    = cpu_a[AW-1:LB];
    assign cpu_lane    = cpu_a[LB-1:0];
    assign lane_onehot = NL'(1) << cpu_lane;

    assign acked   = (state == ST_MEM) && mem_ack;
    // cnt counts completed MEM cycles; the TIMEOUT-th cycle without ack aborts.
    assign timeout = (state == ST_MEM) && !mem_ack && (cnt == TO_LAST);

    assign cpu_ready = (state == ST_RESP);

    line_buffer #(
        .TW     (WW),
        .MW     (MW),
        .BUF_EN (BUF_EN)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .fill_en   (acked && !mem_we),
        .fill_tag  (mem_addr),
        .fill_data (mem_rdata),
        .wr_en     (acked && mem_we),
        .wr_tag    (mem_addr),
        .wr_lane   (lane_q),
        .wr_byte   (byte_q),
        .rd_tag    (cpu_word),
        .rd_lane   (cpu_lane),
        .hit       (buf_hit),
        .rd_byte   (buf_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lane_q    <= '0;
            byte_q    <= '0;
            cnt       <= '0;
            cpu_i     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (!cpu_w && buf_hit) begin
                            cpu_i <= buf_byte;
                            state <= ST_RESP;
                        end else begin
                            // Memory-side outputs load only here, so they
                            // stay stable while mem_req is high.
                            lane_q    <= cpu_lane;
                            byte_q    <= cpu_o;
                            mem_addr  <= cpu_word;
                            mem_we    <= cpu_w;
                            mem_be    <= cpu_w ? lane_onehot : {NL{1'b1}};
                            mem_wdata <= {NL{cpu_o}};
                            mem_req   <= 1'b1;
                            cnt       <= '0;
                            state     <= ST_MEM;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            cpu_i <= pick_lane(mem_rdata, lane_q);
                        end
                        state <= ST_RESP;
                    end else if (cnt == TO_LAST) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            cpu_i <= BUS_ERR_DATA;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (err_clr) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end

endmodule
